// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N_CH producers, the mux and one consumer.
// The slave modport is the mux; the master modport is the producer/consumer side.
interface stream_mux_rr_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
);
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_sel;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sel
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sel
    );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N-channel valid/ready stream mux with a single output register.
// STREAM_MUX_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module stream_mux_rr #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_mux_rr_if.slave     io_bus
);

    localparam int unsigned SUM_W = SEL_W + 1;

    logic              w_ld;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [SEL_W-1:0]  w_base;
    logic [SUM_W-1:0]  w_sum;
    logic [SEL_W-1:0]  w_idx;
    logic [W-1:0]      w_gnt_data;
    logic [N_CH-1:0]   w_in_ready;

    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    // Output register may accept a new beat when empty or draining this cycle.
    assign w_ld = !r_out_valid || io_bus.out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]  r_ptr;

    assign w_base = r_ptr;

    // Pointer moves one past the granted channel, wrapping at N_CH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_ld && w_gnt_vld) begin
            if (w_gnt_idx == SEL_W'(N_CH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_idx + SEL_W'(1);
            end
        end
    end
`else
    assign w_base = '0;
`endif

    // Search channels starting at w_base, wrapping modulo N_CH; first valid wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, w_base} + SUM_W'(k);
            if (w_sum >= SUM_W'(N_CH)) begin
                w_sum = w_sum - SUM_W'(N_CH);
            end
            w_idx = w_sum[SEL_W-1:0];
            if (!w_gnt_vld && io_bus.in_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (SEL_W'(k) == w_gnt_idx) begin
                w_gnt_data = io_bus.in_data[k*W +: W];
            end
        end
    end

    // Ready is one-hot at the winner, and forced low while in reset.
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_ld && w_gnt_vld) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_ld) begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_data <= w_gnt_data;
                r_out_sel  <= w_gnt_idx;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sel   = r_out_sel;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Registered, parametrised N-channel stream multiplexer with valid/ready handshakes on every input and on the output. It picks one requesting channel per cycle, captures that channel's data into a single output register, and reports which channel the beat came from. It is the sequential successor to the plain select-driven data muxes. It sits between several independent producers and one shared consumer.

## Interface
- `N_CH`, default 4: number of input channels, at least 2.
- `W`, default 4: data width per channel, at least 1.
- `SEL_W`, default `$clog2(N_CH)`: width of the channel index. Derived; do not override.

- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_data` input, `N_CH*W` bits: channel c occupies bits `[c*W +: W]`.
- `in_valid` input, `N_CH` bits: per-channel valid.
- `in_ready` output, `N_CH` bits: per-channel ready. Combinational. At most one bit is high.
- `out_data` output, `W` bits: registered data.
- `out_valid` output, 1 bit: registered valid.
- `out_ready` input, 1 bit: consumer ready.
- `out_sel` output, `SEL_W` bits: registered index of the channel that produced `out_data`.

## Operation
- Transfer rules:
  - An input transfer on channel c occurs when `in_valid[c] && in_ready[c]`.
  - An output transfer occurs when `out_valid && out_ready`.
- Load enable: `ld = !out_valid || out_ready`. The output register is empty, or is being emptied this cycle.
- Arbitration happens only when `ld` = 1 and `in_valid != 0`:
  - The winning channel g is chosen per the Configuration section.
  - `in_ready` is one-hot at bit g. All other bits are 0.
  - On the next edge: `out_data <= in_data[g*W +: W]`, `out_sel <= g`, `out_valid <= 1`.
- When `ld` = 1 and `in_valid == 0`:
  - `in_ready` is 0.
  - On the next edge `out_valid <= 0`. `out_data` and `out_sel` keep their values.
- When `ld` = 0 (back-pressure):
  - `in_ready` is 0.
  - `out_data`, `out_sel` and `out_valid` hold.
  - The arbitration pointer holds.
- `in_ready` never depends on `in_data`. It may depend on `in_valid`, `out_valid`, `out_ready` and the pointer.
- Producers may drop `in_valid` without a transfer. The block must not latch or remember ungranted requests.
- While `rst_n` = 0, `in_ready` is forced to 0.

## Timing
- Latency: input transfer on edge k gives `out_valid` = 1 with that data during cycle k+1.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Reset values (asynchronous, immediate on `rst_n` falling):
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0.
  - Arbitration pointer = 0.
  - `in_ready` = 0.
- Reset mid-transfer: a beat held in the output register is discarded. After `rst_n` rises, the first grant is evaluated on the next clock with pointer = 0.
- Simultaneous consume and load (`out_valid && out_ready && in_valid != 0`): the new beat replaces the old one in the same edge. There is no bubble.
- Pointer wrap: after a grant to channel `N_CH-1`, the pointer becomes 0.

## Configuration
- Macro: `STREAM_MUX_RR_EN`.
- Defined (round-robin):
  - The pointer p names the highest-priority channel.
  - Channels are searched p, p+1, …, `N_CH-1`, 0, …, p-1. The first valid channel wins.
  - On every grant to g, `p <= (g+1) mod N_CH`.
- Not defined (fixed priority):
  - The lowest-index valid channel always wins.
  - The pointer register is not implemented. Reset and hold rules for it do not apply.
- The ports are identical in both builds.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream with `out_valid` = 1 → immediately `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `in_ready` = 0000, with no clock edge needed.
- Single channel: `in_valid` = 0100, ch2 data = 4'hA, `out_ready` = 1 → `in_ready` = 0100 that cycle; next cycle `out_valid` = 1, `out_data` = 4'hA, `out_sel` = 2.
- Fairness: `in_valid` = 1111 held, `out_ready` = 1, channel c data = c+1 →
  - with `STREAM_MUX_RR_EN`: `out_sel` sequence 0, 1, 2, 3, 0, 1 and `out_data` 1, 2, 3, 4, 1, 2.
  - without it: `out_sel` stays 0 and `out_data` stays 1.
- Back-pressure: register holds ch1 data 4'h5; `out_ready` = 0 for 3 cycles with `in_valid` = 1111 → `out_data` = 4'h5 stable, `in_ready` = 0000, no input transfer. On `out_ready` = 1, ch1 data is consumed and the next grant is ch2 in the same edge (RR build).
- Wrap-around (RR): reach pointer = 3 via a grant to ch2, then `in_valid` = 1001 → grants ch3 then ch0, `out_sel` 3 then 0.
- Idle drain: one beat is loaded, then `in_valid` = 0000 with `out_ready` = 1 → `out_valid` falls to 0 one cycle after the output transfer, and `out_data` holds its last value.
